cnt_xfer_scheduler: RTL

//  Round-robin scheduler sharing one configurable_2mode_counter among N_REQ

---
 rtl/cnt_xfer_scheduler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cnt_xfer_scheduler.sv
// Round-robin scheduler that lends one shared two-mode counter to N_REQ
// requesters, one fixed-length transfer at a time, and reports completion.
module cnt_xfer_scheduler #(
  parameter int N_REQ          = 4,
  parameter int REQ_ID_WIDTH   = 2,
  parameter int CNT_SIZE       = 40,
  parameter int CNT_SIZE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [2*N_REQ-1:0]        req_mode_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic                      abort_i,
  output logic [1:0]                cnt_mode_o,
  output logic                      cnt_rst_o,
  output logic [CNT_SIZE_WIDTH-1:0] cnt_rst_vector_o,
  input  logic                      cnt_end_i,
  output logic                      busy_o,
  output logic [REQ_ID_WIDTH-1:0]   grant_id_o,
  output logic                      done_o,
  output logic                      done_aborted_o
);

  if (REQ_ID_WIDTH < $clog2(N_REQ)) begin : g_bad_id
    $error("REQ_ID_WIDTH too small for N_REQ");
  end
  if (CNT_SIZE < 1 || CNT_SIZE > (1 << CNT_SIZE_WIDTH)) begin : g_bad_cnt
    $error("CNT_SIZE does not fit CNT_SIZE_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [REQ_ID_WIDTH-1:0] last_grant;
  logic [REQ_ID_WIDTH-1:0] id;
  logic [REQ_ID_WIDTH-1:0] winner;
  logic [1:0]              mode;
  logic [1:0]              win_mode;
  logic                    aborted;
  logic                    aborted_nx;
  logic                    found;
  logic                    hs;

  // First valid requester after the last grant, wrapping modulo N_REQ
  always_comb begin : arb
    int j;
    logic [REQ_ID_WIDTH-1:0] idx;
    j      = 0;
    idx    = '0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j   = (int'(last_grant) + k) % N_REQ;
      idx = REQ_ID_WIDTH'(j);
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign win_mode = req_mode_i[{winner, 1'b0} +: 2];
  assign hs       = (state == IDLE) && found && !rst;

  assign req_ready_o = hs ? (N_REQ'(1) << winner) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_ID_WIDTH'(N_REQ - 1);
      mode       <= 2'b01;
      id         <= '0;
      aborted    <= 1'b0;
    end else begin
      state   <= state_nx;
      aborted <= aborted_nx;
      if (hs) begin
        last_grant <= winner;
        id         <= winner;
        // mode 0 never reaches cnt_end, so run it as a plain count
        mode       <= (win_mode == 2'b00) ? 2'b01 : win_mode;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    aborted_nx = aborted;
    unique case (state)
      IDLE: begin
        if (found) state_nx = RUN;
      end
      RUN: begin
        if (abort_i) begin
          state_nx   = DONE;
          aborted_nx = 1'b1;
        end else if (cnt_end_i) begin
          state_nx   = DONE;
          aborted_nx = 1'b0;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign cnt_rst_o        = (state != RUN);
  assign cnt_mode_o       = (state == RUN) ? mode : 2'b00;
  assign cnt_rst_vector_o = '0;
  assign busy_o           = (state != IDLE);
  assign grant_id_o       = id;
  assign done_o           = (state == DONE);
  assign done_aborted_o   = (state == DONE) && aborted;

endmodule
